// File: rtl/pipe_pkg.sv
// Shared constants and FSM state type for the pipe renderer.
// Contents: visible-area and scroll-span sizes, gap floor, reset values,
// LFSR seed, and the frame-update FSM state enum.
package pipe_pkg;

    localparam int          X_SPAN    = 384;   // horizontal scroll period in columns
    localparam int          VIS_W     = 320;   // visible columns
    localparam int          VIS_H     = 480;   // visible lines
    localparam int          GAP_MIN   = 48;    // lowest gap_top after a wrap
    localparam int          X_STEP    = 96;    // reset spacing between pipes
    localparam logic [8:0]  GAP_RESET = 9'd176;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_renderer_lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, stepping every clock.
// Ports:
//   clk - clock
//   rst - async active-high reset, loads LFSR_SEED
//   q   - current LFSR state (never all-zero since the seed is non-zero)
module lfsr16
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic        fb_d;

    assign fb_d = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= {q_q[14:0], fb_d};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_renderer.sv
// Scrolling-pipe renderer: colours each pixel as pipe / background / blank
// through a 2-stage pipeline and scrolls the pipes once per frame.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   pixel_x, pixel_y            - current pixel from the sync generator
//   in_display                  - pixel is in the visible 320x480 area
//   h_sync_in, v_sync_in        - active-low syncs, delayed 2 cycles to *_out
//   run                         - scroll enable
//   r, g, b                     - pixel colour, 2 cycles after the pixel inputs
//   frame_tick                  - one-cycle pulse when the per-frame update ends
//
// FSM states:
//   IDLE | waiting for the falling edge of v_sync_in
//   UPD  | updating pipe idx_q, one pipe per cycle
//   DONE | pulsing frame_tick, then back to IDLE
module pipe_renderer
    import pipe_pkg::*;
#(
    parameter int NUM_PIPES = 4,
    parameter int PIPE_W    = 32,
    parameter int GAP_H     = 128,
    parameter int SPEED     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] pixel_x,
    input  logic [8:0]  pixel_y,
    input  logic        in_display,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        run,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        frame_tick
);

    localparam int                IDX_W    = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PIPES - 1);

    logic [15:0] lfsr;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Only the low byte feeds the gap offset.
    assign lfsr_unused = ^lfsr[15:8];

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              vs_prev_q;
    logic              frame_tick_q;
    logic [8:0]        pipe_x_q   [NUM_PIPES];
    logic [8:0]        gap_top_q  [NUM_PIPES];
    logic              frame_start;
    logic [8:0]        x_d;
    logic [8:0]        gap_d;

    assign frame_start = vs_prev_q & ~v_sync_in;

    // Scroll step for the pipe currently selected by idx_q.
    always_comb begin
        x_d   = pipe_x_q[idx_q];
        gap_d = gap_top_q[idx_q];
        if (pipe_x_q[idx_q] >= 9'(SPEED)) begin
            x_d = pipe_x_q[idx_q] - 9'(SPEED);
        end else begin
            x_d   = pipe_x_q[idx_q] + 9'(X_SPAN - SPEED);
            gap_d = 9'(GAP_MIN) + {1'b0, lfsr[7:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            vs_prev_q    <= 1'b1;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_q[i]  <= 9'(X_STEP * i);
                gap_top_q[i] <= GAP_RESET;
            end
        end else begin
            vs_prev_q    <= v_sync_in;
            frame_tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q <= UPD;
                        idx_q   <= '0;
                    end
                end
                UPD: begin
                    if (run) begin
                        pipe_x_q[idx_q]  <= x_d;
                        gap_top_q[idx_q] <= gap_d;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    frame_tick_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_tick = frame_tick_q;

    // Stage 1: per-pipe hit flags. Pipes parked at x >= VIS_W are hidden
    // and nothing right of the visible area is ever marked.
    logic [NUM_PIPES-1:0] hit_d;
    logic [NUM_PIPES-1:0] hit_q;
    logic [9:0]           x_end;
    logic [9:0]           y_end;

    always_comb begin
        hit_d = '0;
        x_end = '0;
        y_end = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            x_end = {1'b0, pipe_x_q[i]} + 10'(PIPE_W);
            y_end = {1'b0, gap_top_q[i]} + 10'(GAP_H);
            hit_d[i] = (pipe_x_q[i] < 9'(VIS_W)) && (pixel_x < 11'(VIS_W)) &&
                       (pixel_x >= {2'b00, pipe_x_q[i]}) && (pixel_x < {1'b0, x_end}) &&
                       ((pixel_y < gap_top_q[i]) || ({1'b0, pixel_y} >= y_end));
        end
    end

    logic       disp_q;
    logic [1:0] hs_pipe_q;
    logic [1:0] vs_pipe_q;
    logic       r_q, g_q, b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q     <= '0;
            disp_q    <= 1'b0;
            hs_pipe_q <= 2'b11;
            vs_pipe_q <= 2'b11;
            r_q       <= 1'b0;
            g_q       <= 1'b0;
            b_q       <= 1'b0;
        end else begin
            hit_q     <= hit_d;
            disp_q    <= in_display;
            hs_pipe_q <= {hs_pipe_q[0], h_sync_in};
            vs_pipe_q <= {vs_pipe_q[0], v_sync_in};
            // Stage 2: pipe is green, background is cyan, blanking is black.
            r_q       <= 1'b0;
            g_q       <= disp_q;
            b_q       <= disp_q & ~(|hit_q);
        end
    end

    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign h_sync_out = hs_pipe_q[1];
    assign v_sync_out = vs_pipe_q[1];

endmodule

// File: tb/tb_pipe_renderer.sv
module tb_pipe_renderer;

    localparam int NP = 4;
    localparam int PW = 32;
    localparam int GH = 128;
    localparam int SP = 2;

    logic        clk;
    logic        rst;
    logic [10:0] pixel_x;
    logic [8:0]  pixel_y;
    logic        in_display;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        run;
    logic        r, g, b;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        frame_tick;

    pipe_renderer #(
        .NUM_PIPES (NP),
        .PIPE_W    (PW),
        .GAP_H     (GH),
        .SPEED     (SP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .in_display (in_display),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .run        (run),
        .r          (r),
        .g          (g),
        .b          (b),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR built from the polynomial, stepped alongside the DUT.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct {
        logic [10:0] x;
        logic [8:0]  y;
        logic        disp;
        logic        hs;
        logic        vs;
        logic [2:0]  rgb;
    } vec_t;

    typedef struct {
        int         due;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        int         id;
    } exp_t;

    exp_t        sbq[$];
    vec_t        vecs[14];
    int          exp_x[NP];
    int          exp_gap[NP];
    logic [15:0] snaps[16];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    function automatic logic [2:0] pix_model(input int x, input int y, input logic disp);
        logic hit;
        hit = 1'b0;
        if (!disp) return 3'b000;
        for (int i = 0; i < NP; i++) begin
            if (exp_x[i] < 320 && x < 320 && x >= exp_x[i] && x < exp_x[i] + PW &&
                (y < exp_gap[i] || y >= exp_gap[i] + GH)) hit = 1'b1;
        end
        return hit ? 3'b010 : 3'b011;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NP; i++) begin
            exp_x[i]   = 96 * i;
            exp_gap[i] = 176;
        end
    endtask

    task automatic service();
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check($sformatf("rgb[%0d]", e.id), {29'd0, r, g, b}, {29'd0, e.rgb});
            check($sformatf("hsync[%0d]", e.id), {31'd0, h_sync_out}, {31'd0, e.hs});
            check($sformatf("vsync[%0d]", e.id), {31'd0, v_sync_out}, {31'd0, e.vs});
        end
    endtask

    task automatic drive_pix(input int id, input logic [10:0] x, input logic [8:0] y,
                             input logic disp, input logic hs, input logic vs,
                             input logic [2:0] rgb);
        exp_t e;
        @(negedge clk);
        service();
        pixel_x    = x;
        pixel_y    = y;
        in_display = disp;
        h_sync_in  = hs;
        v_sync_in  = vs;
        e.due = cyc + 2; e.rgb = rgb; e.hs = hs; e.vs = vs; e.id = id;
        sbq.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        service();
        in_display = 1'b0;
        h_sync_in  = 1'b1;
        v_sync_in  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            service();
        end
        check("scoreboard_empty", sbq.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"}, {29'd0, r, g, b}, 0);
        check({tag, "_hs"}, {31'd0, h_sync_out}, 1);
        check({tag, "_vs"}, {31'd0, v_sync_out}, 1);
        check({tag, "_tick"}, {31'd0, frame_tick}, 0);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("%s_x%0d", tag, i), {23'd0, dut.pipe_x_q[i]}, 96 * i);
            check($sformatf("%s_gap%0d", tag, i), {23'd0, dut.gap_top_q[i]}, 176);
        end
    endtask

    // One frame: falling edge of v_sync_in, then watch frame_tick for a bounded window.
    task automatic run_frame(output int ticks, output int lat);
        @(negedge clk);
        v_sync_in = 1'b0;
        @(posedge clk);
        #1 snaps[0] = m_lfsr;
        ticks = 0;
        lat   = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1 snaps[k] = m_lfsr;
            @(negedge clk);
            if (frame_tick) begin
                ticks++;
                if (lat < 0) lat = k;
            end
        end
        v_sync_in = 1'b1;
        if (run) begin
            for (int i = 0; i < NP; i++) begin
                if (exp_x[i] >= SP) exp_x[i] = exp_x[i] - SP;
                else begin
                    exp_x[i]   = exp_x[i] + 384 - SP;
                    exp_gap[i] = 48 + int'(snaps[i][7:0]);
                end
            end
        end
    endtask

    task automatic check_positions(input string tag);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("%s_x%0d", tag, i), {23'd0, dut.pipe_x_q[i]}, exp_x[i]);
            check($sformatf("%s_gap%0d", tag, i), {23'd0, dut.gap_top_q[i]}, exp_gap[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, lat, sum_ticks;

        rst = 1'b1; run = 1'b0;
        pixel_x = '0; pixel_y = '0; in_display = 1'b0;
        h_sync_in = 1'b1; v_sync_in = 1'b1;

        //            x       y      disp  hs    vs    rgb
        vecs[0]  = '{11'd10,  9'd100, 1'b1, 1'b1, 1'b1, 3'b010};
        vecs[1]  = '{11'd10,  9'd200, 1'b1, 1'b0, 1'b1, 3'b011};
        vecs[2]  = '{11'd10,  9'd303, 1'b1, 1'b1, 1'b0, 3'b011};
        vecs[3]  = '{11'd10,  9'd304, 1'b1, 1'b1, 1'b1, 3'b010};
        vecs[4]  = '{11'd31,  9'd0,   1'b1, 1'b0, 1'b0, 3'b010};
        vecs[5]  = '{11'd32,  9'd0,   1'b1, 1'b1, 1'b1, 3'b011};
        vecs[6]  = '{11'd95,  9'd175, 1'b1, 1'b1, 1'b1, 3'b011};
        vecs[7]  = '{11'd96,  9'd175, 1'b1, 1'b0, 1'b1, 3'b010};
        vecs[8]  = '{11'd127, 9'd176, 1'b1, 1'b1, 1'b1, 3'b011};
        vecs[9]  = '{11'd288, 9'd479, 1'b1, 1'b1, 1'b0, 3'b010};
        vecs[10] = '{11'd319, 9'd479, 1'b1, 1'b1, 1'b1, 3'b010};
        vecs[11] = '{11'd10,  9'd100, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[12] = '{11'd300, 9'd300, 1'b0, 1'b1, 1'b1, 3'b000};
        vecs[13] = '{11'd320, 9'd0,   1'b0, 1'b0, 1'b1, 3'b000};

        reset_model();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Rendering from reset positions, run=0 so positions stay put.
        for (int i = 0; i < 14; i++)
            drive_pix(i, vecs[i].x, vecs[i].y, vecs[i].disp, vecs[i].hs, vecs[i].vs, vecs[i].rgb);
        drain();

        // run=0: five frames, five ticks, nothing moves.
        sum_ticks = 0;
        for (int f = 0; f < 5; f++) begin
            run_frame(ticks, lat);
            sum_ticks += ticks;
            check($sformatf("idle_lat%0d", f), lat, NP + 1);
        end
        check("idle_tick_count", sum_ticks, 5);
        check_positions("idle");

        // run=1: one frame from reset positions.
        run = 1'b1;
        run_frame(ticks, lat);
        check("run_ticks", ticks, 1);
        check("run_lat", lat, NP + 1);
        check_positions("run1");
        check("run1_x0_lit", {23'd0, dut.pipe_x_q[0]}, 382);
        check("run1_x3_lit", {23'd0, dut.pipe_x_q[3]}, 286);

        // Scroll pipe 0 to x=330: fully parked beyond the visible area.
        for (int f = 0; f < 26; f++) run_frame(ticks, lat);
        check("park_x0", {23'd0, dut.pipe_x_q[0]}, 330);
        drive_pix(100, 11'd300, 9'd0, 1'b1, 1'b1, 1'b1, pix_model(300, 0, 1'b1));
        drive_pix(101, 11'd319, 9'd0, 1'b1, 1'b1, 1'b1, pix_model(319, 0, 1'b1));
        drive_pix(102, 11'd310, 9'd479, 1'b1, 1'b1, 1'b1, 3'b011);
        drain();

        // Scroll pipe 0 to x=300: clipped at the right edge.
        for (int f = 0; f < 15; f++) run_frame(ticks, lat);
        check("edge_x0", {23'd0, dut.pipe_x_q[0]}, 300);
        check_positions("edge");
        drive_pix(200, 11'd299, 9'd0, 1'b1, 1'b1, 1'b1, pix_model(299, 0, 1'b1));
        drive_pix(201, 11'd300, 9'd0, 1'b1, 1'b0, 1'b1, 3'b010);
        drive_pix(202, 11'd319, 9'd0, 1'b1, 1'b1, 1'b1, 3'b010);
        drive_pix(203, 11'd310, 9'd479, 1'b1, 1'b1, 1'b1, pix_model(310, 479, 1'b1));
        drive_pix(204, 11'd320, 9'd0, 1'b0, 1'b1, 1'b1, 3'b000);
        drain();

        // Reset in the middle of the update of pipe 2.
        @(negedge clk);
        pixel_x = 11'd5; pixel_y = 9'd400; in_display = 1'b1;
        h_sync_in = 1'b0; v_sync_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_rgb", {29'd0, r, g, b}, {29'd0, pix_model(5, 400, 1'b1)});
        check("pre_rst_hs", {31'd0, h_sync_out}, 0);
        check("pre_rst_x0", {23'd0, dut.pipe_x_q[0]}, exp_x[0] - SP);
        rst = 1'b1;
        #1 check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        in_display = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
        reset_model();
        run_frame(ticks, lat);
        check("post_rst_ticks", ticks, 1);
        check("post_rst_lat", lat, NP + 1);
        check_positions("post_rst");
        check("post_rst_x1_lit", {23'd0, dut.pipe_x_q[1]}, 94);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
